// File: rtl/xadc_drp_reader.sv
// xadc_drp_reader: on each XADC end-of-sequence pulse, reads the voltage and
// current-monitor status registers over DRP and presents them as two
// independent valid/ready sample streams. End-of-sequence pulses that arrive
// while a sequence is still in progress are dropped and counted.
// Optional feature macro: XADC_DRP_READER_TIMEOUT_EN (abort a read when
// drp_drdy does not arrive within DRDY_TIMEOUT cycles).
module xadc_drp_reader #(
    parameter logic [6:0] VOLTAGE_ADDR = 7'h13,
    parameter logic [6:0] CURRENT_ADDR = 7'h1B,
    parameter int         DRDY_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        xadc_eos,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic [15:0] voltage_tdata,
    output logic        voltage_tvalid,
    input  logic        voltage_tready,
    output logic [15:0] current_tdata,
    output logic        current_tvalid,
    input  logic        current_tready,
    output logic        busy,
    output logic [7:0]  overrun_count,
    output logic        timeout_error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_V_REQ  = 3'd1,
        S_V_WAIT = 3'd2,
        S_I_REQ  = 3'd3,
        S_I_WAIT = 3'd4,
        S_OUTPUT = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  daddr_q, daddr_d;
    logic        den_q, den_d;
    logic [15:0] vdata_q, vdata_d;
    logic [15:0] cdata_q, cdata_d;
    logic        vvalid_q, vvalid_d;
    logic        cvalid_q, cvalid_d;
    logic        busy_q, busy_d;
    logic [7:0]  ovr_q, ovr_d;
    logic        terr_q, terr_d;

`ifdef XADC_DRP_READER_TIMEOUT_EN
    localparam int WCW = $clog2(DRDY_TIMEOUT);
    localparam logic [WCW-1:0] WCNT_MAX = WCW'(DRDY_TIMEOUT - 1);
    logic [WCW-1:0] wcnt_q, wcnt_d;
`else
    // The timeout length only matters when the timeout feature is built in.
    logic unused_timeout_cfg_s;
    assign unused_timeout_cfg_s = (DRDY_TIMEOUT > 0);
`endif

    // Write side of the DRP is never used: this block only reads.
    assign drp_dwe = 1'b0;
    assign drp_di  = 16'h0000;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        daddr_d  = daddr_q;
        vdata_d  = vdata_q;
        cdata_d  = cdata_q;
        vvalid_d = vvalid_q;
        cvalid_d = cvalid_q;
        ovr_d    = ovr_q;
        terr_d   = 1'b0;
`ifdef XADC_DRP_READER_TIMEOUT_EN
        wcnt_d   = wcnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // drp_drdy is deliberately ignored here so that a read
                // aborted by reset cannot leak into a new sequence.
                if (xadc_eos) begin
                    state_d = S_V_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_V_REQ: begin
                state_d = S_V_WAIT;
`ifdef XADC_DRP_READER_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end
            S_V_WAIT: begin
                if (drp_drdy) begin
                    vdata_d = drp_do;
                    state_d = S_I_REQ;
                end else begin
`ifdef XADC_DRP_READER_TIMEOUT_EN
                    if (wcnt_q == WCNT_MAX) begin
                        state_d = S_IDLE;
                        terr_d  = 1'b1;
                    end else begin
                        wcnt_d  = wcnt_q + WCW'(1);
                    end
`else
                    state_d = S_V_WAIT;
`endif
                end
            end
            S_I_REQ: begin
                state_d = S_I_WAIT;
`ifdef XADC_DRP_READER_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end
            S_I_WAIT: begin
                if (drp_drdy) begin
                    cdata_d  = drp_do;
                    vvalid_d = 1'b1;
                    cvalid_d = 1'b1;
                    state_d  = S_OUTPUT;
                end else begin
`ifdef XADC_DRP_READER_TIMEOUT_EN
                    if (wcnt_q == WCNT_MAX) begin
                        state_d = S_IDLE;
                        terr_d  = 1'b1;
                    end else begin
                        wcnt_d  = wcnt_q + WCW'(1);
                    end
`else
                    state_d = S_I_WAIT;
`endif
                end
            end
            S_OUTPUT: begin
                // Each channel retires on its own handshake; leave once both have.
                vvalid_d = vvalid_q & ~voltage_tready;
                cvalid_d = cvalid_q & ~current_tready;
                if (!vvalid_d && !cvalid_d) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUTPUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A sequence that starts while we are still busy is lost.
        if (xadc_eos && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end else begin
            ovr_d = ovr_d;
        end

        // DRP enable is a one-cycle pulse in the request states; the
        // address changes only when a new request is issued.
        case (state_d)
            S_V_REQ: begin
                den_d   = 1'b1;
                daddr_d = VOLTAGE_ADDR;
            end
            S_I_REQ: begin
                den_d   = 1'b1;
                daddr_d = CURRENT_ADDR;
            end
            default: begin
                den_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            daddr_q  <= 7'h00;
            den_q    <= 1'b0;
            vdata_q  <= 16'h0000;
            cdata_q  <= 16'h0000;
            vvalid_q <= 1'b0;
            cvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 8'h00;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            daddr_q  <= daddr_d;
            den_q    <= den_d;
            vdata_q  <= vdata_d;
            cdata_q  <= cdata_d;
            vvalid_q <= vvalid_d;
            cvalid_q <= cvalid_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
            terr_q   <= terr_d;
        end
    end

`ifdef XADC_DRP_READER_TIMEOUT_EN
    // drdy wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`endif

    assign drp_daddr      = daddr_q;
    assign drp_den        = den_q;
    assign voltage_tdata  = vdata_q;
    assign voltage_tvalid = vvalid_q;
    assign current_tdata  = cdata_q;
    assign current_tvalid = cvalid_q;
    assign busy           = busy_q;
    assign overrun_count  = ovr_q;
    assign timeout_error  = terr_q;

endmodule

// File: tb/tb_xadc_drp_reader.sv
// Directed testbench for xadc_drp_reader with a one-cycle-latency DRP model.
module tb_xadc_drp_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        xadc_eos;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;
    logic [15:0] voltage_tdata;
    logic        voltage_tvalid;
    logic        voltage_tready;
    logic [15:0] current_tdata;
    logic        current_tvalid;
    logic        current_tready;
    logic        busy;
    logic [7:0]  overrun_count;
    logic        timeout_error;

    // DRP model: drdy one cycle after den, data chosen by address.
    logic        model_en;
    logic        mdl_drdy = 1'b0;
    logic [15:0] mdl_do = 16'h0000;
    logic        man_drdy;
    int          den_cnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    assign drp_drdy = model_en ? mdl_drdy : man_drdy;
    assign drp_do   = mdl_do;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mdl_drdy <= drp_den;
        if (drp_den === 1'b1) begin
            den_cnt <= den_cnt + 1;
            if (drp_daddr == 7'h13)      mdl_do <= 16'hABC0;
            else if (drp_daddr == 7'h1B) mdl_do <= 16'h1230;
            else                         mdl_do <= 16'hDEAD;
        end
    end

    xadc_drp_reader #(
        .VOLTAGE_ADDR(7'h13),
        .CURRENT_ADDR(7'h1B),
        .DRDY_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .xadc_eos(xadc_eos),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe),
        .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy),
        .voltage_tdata(voltage_tdata), .voltage_tvalid(voltage_tvalid),
        .voltage_tready(voltage_tready),
        .current_tdata(current_tdata), .current_tvalid(current_tvalid),
        .current_tready(current_tready),
        .busy(busy), .overrun_count(overrun_count), .timeout_error(timeout_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue eos and step through a full read; returns at the first valid cycle.
    task automatic full_read(input string tag);
        xadc_eos = 1'b1;
        step();
        xadc_eos = 1'b0;
        check({tag, "_den1"}, {31'd0, drp_den}, 32'd1);
        check({tag, "_addr1"}, {25'd0, drp_daddr}, 32'h13);
        step();
        step();
        check({tag, "_den2"}, {31'd0, drp_den}, 32'd1);
        check({tag, "_addr2"}, {25'd0, drp_daddr}, 32'h1B);
        step();
        check({tag, "_vvalid_early"}, {31'd0, voltage_tvalid}, 32'd0);
        step();
        check({tag, "_vvalid"}, {31'd0, voltage_tvalid}, 32'd1);
        check({tag, "_cvalid"}, {31'd0, current_tvalid}, 32'd1);
        check({tag, "_vdata"}, {16'd0, voltage_tdata}, 32'hABC0);
        check({tag, "_cdata"}, {16'd0, current_tdata}, 32'h1230);
    endtask

    initial begin
        int den_snap;
        rst = 1'b1;
        xadc_eos = 1'b0;
        voltage_tready = 1'b0;
        current_tready = 1'b0;
        model_en = 1'b1;
        man_drdy = 1'b0;
        step();
        step();

        // Reset values
        check("rst_den", {31'd0, drp_den}, 32'd0);
        check("rst_daddr", {25'd0, drp_daddr}, 32'd0);
        check("rst_dwe", {31'd0, drp_dwe}, 32'd0);
        check("rst_di", {16'd0, drp_di}, 32'd0);
        check("rst_vdata", {16'd0, voltage_tdata}, 32'd0);
        check("rst_cvalid", {31'd0, current_tvalid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovr", {24'd0, overrun_count}, 32'd0);
        check("rst_terr", {31'd0, timeout_error}, 32'd0);
        rst = 1'b0;
        step();

        // Basic read, then independent handshakes
        full_read("basic");
        check("basic_dencnt", den_cnt, 32'd2);
        check("basic_ovr", {24'd0, overrun_count}, 32'd0);
        voltage_tready = 1'b1;
        step();
        check("hs_vvalid_drop", {31'd0, voltage_tvalid}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            check("hs_cvalid_hold", {31'd0, current_tvalid}, 32'd1);
            check("hs_cdata_hold", {16'd0, current_tdata}, 32'h1230);
            check("hs_busy_hold", {31'd0, busy}, 32'd1);
            step();
        end
        current_tready = 1'b1;
        step();
        check("hs_cvalid_drop", {31'd0, current_tvalid}, 32'd0);
        check("hs_busy_drop", {31'd0, busy}, 32'd0);
        voltage_tready = 1'b0;
        current_tready = 1'b0;
        step();

        // Overrun: eos pulses while holding samples in OUTPUT
        full_read("ovr");
        den_snap = den_cnt;
        for (int i = 0; i < 3; i++) begin
            xadc_eos = 1'b1;
            step();
            xadc_eos = 1'b0;
            step();
        end
        check("ovr_count3", {24'd0, overrun_count}, 32'd3);
        check("ovr_no_read", den_cnt, den_snap);
        for (int i = 0; i < 300; i++) begin
            xadc_eos = 1'b1;
            step();
            xadc_eos = 1'b0;
            step();
        end
        check("ovr_sat", {24'd0, overrun_count}, 32'd255);
        check("ovr_no_read2", den_cnt, den_snap);
        voltage_tready = 1'b1;
        current_tready = 1'b1;
        step();
        check("ovr_both_hs_valid", {30'd0, voltage_tvalid, current_tvalid}, 32'd0);
        check("ovr_both_hs_busy", {31'd0, busy}, 32'd0);
        voltage_tready = 1'b0;
        current_tready = 1'b0;
        step();

        // Reset while waiting for the voltage drdy
        model_en = 1'b0;
        xadc_eos = 1'b1;
        step();
        xadc_eos = 1'b0;
        step();
        check("rmid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rmid_busy_rst", {31'd0, busy}, 32'd0);
        check("rmid_ovr_rst", {24'd0, overrun_count}, 32'd0);
        step();
        rst = 1'b0;
        man_drdy = 1'b1;
        den_snap = den_cnt;
        step();
        man_drdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rmid_den", {31'd0, drp_den}, 32'd0);
            check("rmid_vvalid", {31'd0, voltage_tvalid}, 32'd0);
            check("rmid_busy_idle", {31'd0, busy}, 32'd0);
            step();
        end
        check("rmid_no_read", den_cnt, den_snap);
        model_en = 1'b1;
        full_read("after_rst");
        voltage_tready = 1'b1;
        current_tready = 1'b1;
        step();
        step();
        check("after_rst_idle", {31'd0, busy}, 32'd0);
        voltage_tready = 1'b0;
        current_tready = 1'b0;

`ifdef XADC_DRP_READER_TIMEOUT_EN
        // Timeout: drdy withheld in V_WAIT
        model_en = 1'b0;
        man_drdy = 1'b0;
        xadc_eos = 1'b1;
        step();
        xadc_eos = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            check("to_wait_terr", {31'd0, timeout_error}, 32'd0);
            step();
        end
        check("to_pulse", {31'd0, timeout_error}, 32'd1);
        check("to_idle", {31'd0, busy}, 32'd0);
        check("to_no_valid", {30'd0, voltage_tvalid, current_tvalid}, 32'd0);
        step();
        check("to_pulse_end", {31'd0, timeout_error}, 32'd0);
        model_en = 1'b1;
        full_read("after_to");
        voltage_tready = 1'b1;
        current_tready = 1'b1;
        step();
        step();
        check("after_to_idle", {31'd0, busy}, 32'd0);
`else
        check("terr_tied", {31'd0, timeout_error}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
